// File: rtl/canvas_buffer.sv
// DIM x DIM pixel canvas with brush painting, row-wise clear, registered read port and a
// row-major valid/ready raster stream. Define CANVAS_SOFT_BRUSH_EN for the soft-edged brush.
module canvas_buffer #(
  parameter int              DIM     = 28,
  parameter int              PIX_W   = 16,
  parameter int              BRUSH   = 1,
  parameter logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}},
  parameter int              CW      = $clog2(DIM)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             paint_en,
  input  logic [CW-1:0]    paint_x,
  input  logic [CW-1:0]    paint_y,
  input  logic             clear,
  input  logic             stream_start,
  output logic             stream_valid,
  input  logic             stream_ready,
  output logic [PIX_W-1:0] stream_data,
  output logic             stream_last,
  output logic             busy,
  input  logic [CW-1:0]    rd_x,
  input  logic [CW-1:0]    rd_y,
  output logic [PIX_W-1:0] rd_data
);

  localparam int             FW    = $clog2(2 * BRUSH + 2);
  localparam logic [FW-1:0]  FLAST = FW'(2 * BRUSH);

  typedef enum logic [1:0] {StIdle, StPaint, StClear, StStream} state_e;

  state_e                         state_q;
  logic [DIM-1:0][PIX_W-1:0]      canvas [DIM];
  logic [CW-1:0]                  px_q, py_q, cy_q, sx_q, sy_q;
  logic [FW-1:0]                  dx_q, dy_q;

  int                             tx, ty;
  logic                           in_range;
  logic [CW-1:0]                  wx, wy, nx, ny;
  logic [PIX_W-1:0]               wval;
  logic                           s_wrap, n_last, rd_hit;
`ifdef CANVAS_SOFT_BRUSH_EN
  logic [PIX_W-1:0]               cur;
  logic [PIX_W:0]                 sum;
`endif

  always_comb begin
    // Brush cell relative to the latched centre; signed so off-canvas cells are detectable.
    tx       = int'(px_q) + int'(dx_q) - BRUSH;
    ty       = int'(py_q) + int'(dy_q) - BRUSH;
    in_range = (tx >= 0) && (tx < DIM) && (ty >= 0) && (ty < DIM);
    wx       = tx[CW-1:0];
    wy       = ty[CW-1:0];
`ifdef CANVAS_SOFT_BRUSH_EN
    cur = in_range ? canvas[wy][wx] : '0;
    sum = {1'b0, cur} + {1'b0, PIX_MAX >> 1};
    if ((int'(dx_q) == BRUSH) && (int'(dy_q) == BRUSH)) begin
      wval = PIX_MAX;
    end else if (sum > {1'b0, PIX_MAX}) begin
      wval = PIX_MAX;
    end else begin
      wval = sum[PIX_W-1:0];
    end
`else
    wval = PIX_MAX;
`endif
    s_wrap = (int'(sx_q) == DIM - 1);
    nx     = s_wrap ? '0 : sx_q + CW'(1);
    ny     = s_wrap ? sy_q + CW'(1) : sy_q;
    n_last = (int'(nx) == DIM - 1) && (int'(ny) == DIM - 1);
    rd_hit = (int'(rd_x) < DIM) && (int'(rd_y) < DIM);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      canvas       <= '{default: '0};
      px_q         <= '0;
      py_q         <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      cy_q         <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      busy         <= 1'b0;
      stream_valid <= 1'b0;
      stream_last  <= 1'b0;
      stream_data  <= '0;
      rd_data      <= '0;
    end else begin
      rd_data <= rd_hit ? canvas[rd_y][rd_x] : '0;
      unique case (state_q)
        StIdle: begin
          if (clear) begin
            state_q <= StClear;
            cy_q    <= '0;
            busy    <= 1'b1;
          end else if (stream_start) begin
            state_q <= StStream;
            sx_q    <= '0;
            sy_q    <= '0;
            busy    <= 1'b1;
          end else if (paint_en) begin
            state_q <= StPaint;
            px_q    <= paint_x;
            py_q    <= paint_y;
            dx_q    <= '0;
            dy_q    <= '0;
            busy    <= 1'b1;
          end
        end
        StPaint: begin
          if (in_range) canvas[wy][wx] <= wval;
          if (dx_q == FLAST) begin
            dx_q <= '0;
            if (dy_q == FLAST) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              dy_q <= dy_q + FW'(1);
            end
          end else begin
            dx_q <= dx_q + FW'(1);
          end
        end
        StClear: begin
          canvas[cy_q] <= '0;
          if (int'(cy_q) == DIM - 1) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            cy_q <= cy_q + CW'(1);
          end
        end
        StStream: begin
          // First cycle after entry loads pixel 0; afterwards advance only on a transfer.
          if (!stream_valid) begin
            stream_valid <= 1'b1;
            stream_data  <= canvas[sy_q][sx_q];
            stream_last  <= 1'b0;
          end else if (stream_ready) begin
            if (stream_last) begin
              stream_valid <= 1'b0;
              stream_last  <= 1'b0;
              stream_data  <= '0;
              state_q      <= StIdle;
              busy         <= 1'b0;
            end else begin
              sx_q        <= nx;
              sy_q        <= ny;
              stream_data <= canvas[ny][nx];
              stream_last <= n_last;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_buffer.sv
// Scoreboard bench for canvas_buffer: a 2-D array model supplies expected read-port and
// stream values; a negedge monitor pops and compares them as the DUT presents outputs.
module tb_canvas_buffer;

  localparam int DIM   = 28;
  localparam int PIX_W = 16;
  localparam int BRUSH = 1;
  localparam int CW    = $clog2(DIM);
  localparam int NPIX  = DIM * DIM;
  localparam int PMAX  = 65535;
  localparam int FOOT  = (2 * BRUSH + 1) * (2 * BRUSH + 1);

  logic             Clk = 1'b0;
  logic             Reset, paint_en, clear, stream_start, stream_ready;
  logic [CW-1:0]    paint_x, paint_y, rd_x, rd_y;
  logic             stream_valid, stream_last, busy;
  logic [PIX_W-1:0] stream_data, rd_data;

  canvas_buffer #(.DIM(DIM), .PIX_W(PIX_W), .BRUSH(BRUSH)) dut (
    .Clk(Clk), .Reset(Reset), .paint_en(paint_en), .paint_x(paint_x), .paint_y(paint_y),
    .clear(clear), .stream_start(stream_start), .stream_valid(stream_valid),
    .stream_ready(stream_ready), .stream_data(stream_data), .stream_last(stream_last),
    .busy(busy), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int beats    = 0;
  int model [DIM][DIM];
  int expd [$];
  int expl [$];
  int rdq [$];
  logic rd_req = 1'b0;
  logic rd_pend = 1'b0;
  logic sv_prev = 1'b0, sr_prev = 1'b0, sl_prev = 1'b0;
  logic [PIX_W-1:0] sd_prev = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got an output with no expected value, expected none", nm);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference model
  function automatic int mget(int x, int y);
    if (x < 0 || x >= DIM || y < 0 || y >= DIM) return 0;
    return model[y][x];
  endfunction

  function automatic void m_clear();
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++) model[y][x] = 0;
  endfunction

  function automatic void m_paint(int cx, int cy);
    for (int dy = -BRUSH; dy <= BRUSH; dy++) begin
      for (int dx = -BRUSH; dx <= BRUSH; dx++) begin
        int x = cx + dx;
        int y = cy + dy;
        if (x >= 0 && x < DIM && y >= 0 && y < DIM) begin
`ifdef CANVAS_SOFT_BRUSH_EN
          if (dx == 0 && dy == 0) model[y][x] = PMAX;
          else model[y][x] = (model[y][x] + PMAX / 2 > PMAX) ? PMAX : model[y][x] + PMAX / 2;
`else
          model[y][x] = PMAX;
`endif
        end
      end
    end
  endfunction

  // Monitor / scoreboard
  always @(negedge Clk) begin
    if (!Reset) begin
      if (rd_pend) begin
        if (rdq.size() == 0) flag("rd_unexpected");
        else chk("rd_data", 32'(rd_data), rdq.pop_front());
      end
      if (stream_valid && sv_prev && !sr_prev) begin
        chk("hold_data", 32'(stream_data), 32'(sd_prev));
        chk("hold_last", 32'(stream_last), 32'(sl_prev));
      end
      if (stream_valid && stream_ready) begin
        if (expd.size() == 0) flag("extra_beat");
        else begin
          chk($sformatf("beat_data[%0d]", NPIX - expd.size()), 32'(stream_data), expd.pop_front());
          chk("beat_last", 32'(stream_last), expl.pop_front());
        end
        beats++;
      end
    end
    rd_pend = rd_req && !Reset;
    sv_prev = stream_valid;
    sr_prev = stream_ready;
    sd_prev = stream_data;
    sl_prev = stream_last;
  end

  task automatic rd_push(input int x, input int y, input int e);
    rd_x   = CW'(x);
    rd_y   = CW'(y);
    rd_req = 1'b1;
    rdq.push_back(e);
    tick();
  endtask

  task automatic rd_drain();
    rd_req = 1'b0;
    tick();
    tick();
    chk("rd_drained", rdq.size(), 0);
  endtask

  task automatic sweep();
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++) rd_push(x, y, mget(x, y));
    rd_drain();
  endtask

  task automatic paint(input int x, input int y);
    int n = 0;
    paint_x  = CW'(x);
    paint_y  = CW'(y);
    paint_en = 1'b1;
    tick();
    paint_en = 1'b0;
    m_paint(x, y);
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk($sformatf("paint_busy(%0d,%0d)", x, y), n, FOOT);
  endtask

  task automatic do_clear(input bit with_paint);
    int n = 0;
    clear    = 1'b1;
    paint_en = with_paint;
    paint_x  = CW'(12);
    paint_y  = CW'(12);
    tick();
    clear    = 1'b0;
    paint_en = 1'b0;
    m_clear();
    while (busy && n < 200) begin
      paint_en = (n == 5);  // ignored: arrives while busy
      paint_x  = CW'(3);
      paint_y  = CW'(3);
      n++;
      tick();
    end
    paint_en = 1'b0;
    chk("clear_busy", n, DIM);
    tick();
    chk("no_queued_paint", 32'(busy), 0);
  endtask

  task automatic load_stream_exp();
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++) begin
        expd.push_back(model[y][x]);
        expl.push_back((y * DIM + x == NPIX - 1) ? 1 : 0);
      end
  endtask

  // mode 0: ready toggles 1,0,1,0..; mode 1: random; mode 2: always ready
  task automatic run_stream(input int mode);
    int n  = 0;
    int b0 = beats;
    load_stream_exp();
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
    while (busy && n < 5000) begin
      if (mode == 0) stream_ready = (n % 2 == 0);
      else if (mode == 1) stream_ready = 1'($urandom_range(0, 1));
      else stream_ready = 1'b1;
      n++;
      tick();
    end
    stream_ready = 1'b0;
    chk("stream_beats", beats - b0, NPIX);
    chk("stream_exp_left", expd.size(), 0);
    chk("stream_idle_valid", 32'(stream_valid), 0);
    chk("stream_idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int n, b0;
    Reset = 1'b1; paint_en = 1'b0; clear = 1'b0; stream_start = 1'b0; stream_ready = 1'b0;
    paint_x = '0; paint_y = '0; rd_x = '0; rd_y = '0;
    m_clear();
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(stream_valid), 0);
    chk("rst_last", 32'(stream_last), 0);
    chk("rst_data", 32'(stream_data), 0);
    chk("rst_rd", 32'(rd_data), 0);
    Reset = 1'b0;

    sweep();
    rd_push(30, 3, 0);
    rd_push(2, 29, 0);
    rd_drain();

    paint(5, 5);
    sweep();
    run_stream(0);

    paint(0, 27);
    sweep();

    do_clear(1'b1);
    sweep();

    repeat (8) begin
      if ($urandom_range(0, 7) == 0) do_clear(1'b0);
      else paint(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end
    run_stream(1);
    repeat (40) begin
      n = int'($urandom_range(0, 31));
      b0 = int'($urandom_range(0, 31));
      rd_push(n, b0, mget(n, b0));
    end
    rd_drain();

    // Reset in the middle of a stream
    load_stream_exp();
    b0 = beats;
    n = 0;
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
    while (beats - b0 < 300 && n < 3000) begin
      stream_ready = 1'($urandom_range(0, 1));
      n++;
      tick();
    end
    chk("reached_beat_300", beats - b0, 300);
    Reset = 1'b1;
    tick();
    chk("abort_valid", 32'(stream_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    Reset = 1'b0;
    stream_ready = 1'b0;
    expd.delete();
    expl.delete();
    m_clear();
    sweep();
    run_stream(2);

`ifdef CANVAS_SOFT_BRUSH_EN
    paint(5, 5);
    paint(5, 5);
    rd_push(5, 5, 'hFFFF);
    rd_push(4, 5, 'hFFFE);
    rd_drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/canvas_buffer.md
Name: canvas_buffer

Overview:
Parametrised drawing canvas of DIM x DIM pixels, PIX_W bits each, with brush-based painting, row-wise clear, a registered pixel read port for the colour mapper, and a valid/ready raster stream that feeds pixels in row-major order to the inference engine. Sits between the pointer/mouse logic and both the VGA colour mapper and the network input. It supersedes the flat fixed-size canvas array with a sequenced, handshaked block.

Parameters:
DIM, 28, canvas width and height in pixels (2..64)
PIX_W, 16, bits per pixel
BRUSH, 1, brush radius in cells; the footprint is (2*BRUSH+1)^2 cells
PIX_MAX, {PIX_W{1'b1}}, ink value written by the brush
CW, $clog2(DIM), coordinate width (derived; not to be overridden)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
paint_en  in  1  request a brush stamp at (paint_x, paint_y)
paint_x  in  CW  brush centre column
paint_y  in  CW  brush centre row
clear  in  1  request a full canvas clear
stream_start  in  1  request a raster stream of the canvas
stream_valid  out  1  stream_data is valid
stream_ready  in  1  consumer accepts the current pixel
stream_data  out  PIX_W  current streamed pixel
stream_last  out  1  high with the final pixel, index DIM*DIM-1
busy  out  1  FSM is not in IDLE
rd_x  in  CW  read-port column
rd_y  in  CW  read-port row
rd_data  out  PIX_W  pixel at (rd_x, rd_y), registered

Behaviour:
- Reset values: all canvas cells 0, FSM to IDLE. All outputs are 0: busy, stream_valid, stream_last, stream_data and rd_data. Reset asserted mid-operation aborts the operation within one cycle, with no partial stream beat left valid.
- FSM states are IDLE, PAINT, CLEAR and STREAM. busy is 1 in every state except IDLE.
- IDLE priority when several requests arrive together: clear, then stream_start, then paint_en. Lower-priority requests in the same cycle are dropped, not queued. Any request arriving while busy=1 is ignored.
- PAINT:
  - paint_x and paint_y are latched on entry.
  - The block iterates dy = -BRUSH..BRUSH (outer loop) and dx = -BRUSH..BRUSH (inner loop), one cell per cycle, for exactly (2*BRUSH+1)^2 cycles, then returns to IDLE.
  - Cells with x+dx or y+dy outside 0..DIM-1 are skipped: the cycle is still spent, with no write and no wrap-around.
  - A paint centre latched at or above DIM is legal; only in-range cells are written.
- CLEAR: zeroes one full row per cycle, rows 0..DIM-1, so it lasts DIM cycles, then returns to IDLE.
- STREAM:
  - Index runs 0..DIM*DIM-1, row-major: index = y*DIM + x.
  - stream_valid rises the cycle after entry.
  - A beat transfers when stream_valid && stream_ready. The index then advances and the next pixel appears the following cycle.
  - While stream_ready=0, stream_data and stream_last hold stable.
  - After the beat with stream_last=1 transfers, stream_valid drops and the FSM returns to IDLE.
  - The canvas cannot change during STREAM because paint and clear requests are ignored.
- Read port:
  - rd_data equals cell(rd_x, rd_y) one cycle after the address is presented. It is available in every state.
  - It shows writes committed on or before the previous edge. A same-cycle write and read return the old value.
  - Out-of-range rd_x or rd_y returns 0.
- Arithmetic: any brush write that adds to a cell saturates at PIX_MAX and never wraps.

Optional Feature:
CANVAS_SOFT_BRUSH_EN
- Defined: the centre cell is set to PIX_MAX. Every other footprint cell gets a saturating add of PIX_MAX>>1, capped at PIX_MAX.
- Undefined: every in-range footprint cell is set to PIX_MAX.
- Cycle counts and boundary skipping are identical in both builds.

Test Plan:
Test defaults are DIM=28, PIX_W=16, BRUSH=1, soft brush undefined.
1. Reset, then read all 784 cells through rd_x/rd_y -> every rd_data = 0; busy = 0; stream_valid = 0.
2. paint_en at (5,5) -> busy = 1 for exactly 9 cycles. Cells (4..6, 4..6) = 16'hFFFF; cells (3,5) and (7,5) stay 0.
3. paint_en at (0,27) -> only (0,26), (1,26), (0,27) and (1,27) are written. Cell (27,0) stays 0 (no wrap). Still 9 busy cycles.
4. After test 2, stream_start with stream_ready toggling 1,0,1,0… -> exactly 784 beats. The beat at index 4*28+4 = 116 carries 16'hFFFF. Data is stable while ready=0. stream_last is high only on beat 783. busy returns to 0.
5. clear and paint_en asserted in the same cycle -> CLEAR wins: 28 busy cycles, all cells 0, and the paint is dropped. A paint_en pulse during CLEAR is also ignored.
6. Reset asserted at stream beat 300 -> next cycle: stream_valid = 0, busy = 0 and all cells 0. A new stream_start then streams 784 zero beats. With CANVAS_SOFT_BRUSH_EN defined, painting (5,5) twice gives centre 16'hFFFF and neighbour (4,5) = 16'hFFFE.
